mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the shared synchronous byte-addressed RAM (one access per grant) between two requesters.
- The requesters are the CPU instruction-fetch port (word reads only) and the data port (byte/half/word reads and writes).
- Performs round-robin arbitration, size/alignment checking, RAM strobe sequencing, read-data capture and zero-extension.
- Returns a one-cycle done pulse to the granted requester.

Parameters:
- ADDR_WIDTH, 14, byte address width; matches RAM address port.
- DATA_WIDTH, 32, word width; fixed at 32 (4 bytes).
- RD_LATENCY, 1, cycles the RAM strobes are held per access; legal range 1..4.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- if_req  input  1  fetch request; level, held until if_done
- if_addr  input  ADDR_WIDTH  fetch byte address
- if_done  output  1  one-cycle completion pulse to fetch port
- if_err  output  1  valid with if_done; alignment abort
- if_rdata  output  DATA_WIDTH  fetched word; valid with if_done
- d_req  input  1  data request; level, held until d_done
- d_we  input  1  1 = write, 0 = read
- d_size  input  2  00 byte, 10 half, 11 word, 01 illegal
- d_addr  input  ADDR_WIDTH  data byte address
- d_wdata  input  DATA_WIDTH  write data, little-endian lanes from bit 0
- d_done  output  1  one-cycle completion pulse to data port
- d_err  output  1  valid with d_done; size/alignment abort
- d_rdata  output  DATA_WIDTH  read data, zero-extended; valid with d_done
- ram_address  output  ADDR_WIDTH  RAM address
- ram_data_input  output  DATA_WIDTH  RAM write data
- ram_data_output  input  DATA_WIDTH  RAM read data (high-Z when not reading)
- ram_cs  output  1  RAM chip select
- ram_we  output  1  RAM write enable
- ram_oe  output  1  RAM output enable
- ram_data_size  output  2  RAM access size, same encoding as d_size
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset: state = IDLE, last_grant = DATA (fetch wins first tie).
- Reset: all outputs 0, including the ram_* strobes, if_*/d_* done, err and rdata.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high, grant one requester and latch its addr, size, we and wdata.
  - Fetch grants force size = 11 and we = 0.
  - Tie: grant the requester not in last_grant. Update last_grant on every grant.
- Check in IDLE at grant time:
  - Error cases: size 01, half with addr[0] = 1, or word with addr[1:0] != 00.
  - On error: go directly to DONE with err = 1. No ram_cs is asserted.
  - Otherwise go to ACCESS with counter = 0.
- ACCESS:
  - Drive ram_cs = 1, ram_address, ram_data_size = latched size, ram_we = latched we.
  - Drive ram_oe = !we and ram_data_input = latched wdata.
  - Counter increments each cycle. After RD_LATENCY cycles go to DONE.
  - On the final ACCESS edge, read data is registered from ram_data_output, masked by size:
    - byte: bits [7:0], upper bits 0
    - half: bits [15:0], upper bits 0
    - word: all bits
  - No other ram_data_output sample is used, so high-Z is never captured.
- DONE:
  - ram_cs = ram_we = ram_oe = 0.
  - Exactly one of if_done / d_done = 1 for this single cycle, with its err and rdata.
  - Next state: IDLE.
- rdata hold: rdata holds its last value after done. rdata is 0 for writes and errors.
- Latency: req sampled high in IDLE at edge N gives done high in cycle N+RD_LATENCY+1.
  - Error path: done high in cycle N+1.
  - Minimum spacing between grants is RD_LATENCY+2 cycles.
- Request changes while busy: requests are not re-sampled. Deasserting req mid-op does not cancel the op; done is still pulsed.
- After done, a requester still holding req in IDLE is treated as a new request.
- Address arithmetic: no wrap handling in the controller. Aligned word at top address 2^ADDR_WIDTH-4 is legal.
- Reset mid-operation:
  - Immediate return to reset values; no done pulse.
  - A write is committed iff a RAM clock edge with ram_cs & ram_we occurred before rst rose.

Test Plan:
- Reset, then fetch read: RAM[0x10..0x13] = EF BE AD DE, if_req with if_addr = 0x10 at edge 0 -> if_done = 1 in cycle 2, if_rdata = 0xDEADBEEF, if_err = 0; ram_cs high only in cycle 1.
- Simultaneous requests: if_req and d_req (read, word, 0x20) held continuously -> grant order fetch, data, fetch, data; done pulses 3 cycles apart (RD_LATENCY = 1), never both high together.
- Byte write then word read: d_we = 1, size 00, addr 0x41, wdata 0xAABBCC5A, then word read of 0x40 from zeroed RAM -> d_rdata = 0x00005A00; a byte read of 0x41 returns 0x0000005A.
- Misaligned: half at 0x03, word at 0x22, size 01 -> each gives d_done with d_err = 1 one cycle after grant, ram_cs stays 0, RAM contents unchanged.
- RD_LATENCY = 3 build: word read -> ram_cs high exactly 3 cycles, d_done in cycle 4; busy high in cycles 1-4.
- Reset mid-operation: rst asserted in first ACCESS cycle of a read -> outputs 0 asynchronously, no done pulse; after release, a pending if_req is granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sequencing a shared byte-addressed RAM between the instruction-fetch
// port and the data port, with size/alignment checking and zero-extended read capture.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic                  if_err,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_input,
  input  logic [DATA_WIDTH-1:0] ram_data_output,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [1:0]            ram_data_size,
  output logic                  busy
);

  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] CntLast = CntW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic                  last_data_q, last_data_d;  // 1: most recent grant went to data port
  logic                  own_data_q, own_data_d;    // owner of the operation in flight
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  cs_q, cs_d;
  logic                  wen_q, wen_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  if_done_q, if_done_d;
  logic                  if_err_q, if_err_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  d_done_q, d_done_d;
  logic                  d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic                  pick_data;
  logic                  req_we;
  logic                  bad_align;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] rd_masked;

  always_comb begin
    // On a tie the port that did not win last time is served.
    pick_data = d_req & (~if_req | ~last_data_q);
    req_size  = pick_data ? d_size : 2'b11;
    req_addr  = pick_data ? d_addr : if_addr;
    req_we    = pick_data & d_we;
    case (req_size)
      2'b01:   bad_align = 1'b1;
      2'b10:   bad_align = req_addr[0];
      2'b11:   bad_align = |req_addr[1:0];
      default: bad_align = 1'b0;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   rd_masked = {{(DATA_WIDTH-8){1'b0}}, ram_data_output[7:0]};
      2'b10:   rd_masked = {{(DATA_WIDTH-16){1'b0}}, ram_data_output[15:0]};
      default: rd_masked = ram_data_output;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    own_data_d  = own_data_q;
    addr_d      = addr_q;
    size_d      = size_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cs_d        = cs_q;
    wen_d       = wen_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          last_data_d = pick_data;
          own_data_d  = pick_data;
          addr_d      = req_addr;
          size_d      = req_size;
          we_d        = req_we;
          wdata_d     = pick_data ? d_wdata : '0;
          busy_d      = 1'b1;
          if (bad_align) begin
            state_d = StDone;
            if (pick_data) begin
              d_done_d  = 1'b1;
              d_err_d   = 1'b1;
              d_rdata_d = '0;
            end else begin
              if_done_d  = 1'b1;
              if_err_d   = 1'b1;
              if_rdata_d = '0;
            end
          end else begin
            state_d = StAccess;
            cnt_d   = '0;
            cs_d    = 1'b1;
            wen_d   = req_we;
            oe_d    = ~req_we;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          cs_d    = 1'b0;
          wen_d   = 1'b0;
          oe_d    = 1'b0;
          // Only this edge samples the RAM bus, so a floating bus is never captured.
          if (own_data_q) begin
            d_done_d  = 1'b1;
            d_rdata_d = we_q ? '0 : rd_masked;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = rd_masked;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_data_q <= 1'b1;
      own_data_q  <= 1'b0;
      addr_q      <= '0;
      size_q      <= 2'b00;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cs_q        <= 1'b0;
      wen_q       <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      own_data_q  <= own_data_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cs_q        <= cs_d;
      wen_q       <= wen_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      if_done_q   <= if_done_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign ram_address    = addr_q;
  assign ram_data_input = wdata_q;
  assign ram_data_size  = size_q;
  assign ram_cs         = cs_q;
  assign ram_we         = wen_q;
  assign ram_oe         = oe_q;
  assign busy           = busy_q;
  assign if_done        = if_done_q;
  assign if_err         = if_err_q;
  assign if_rdata       = if_rdata_q;
  assign d_done         = d_done_q;
  assign d_err          = d_err_q;
  assign d_rdata        = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array RAM, byte-level reference memory and directed plus
// randomized transactions; a second instance covers a three-cycle access build.
module tb_mem_port_arbiter;
  localparam int AW  = 14;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          if_req, if_done, if_err;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          d_req, d_we, d_done, d_err;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data_input, ram_data_output;
  logic          ram_cs, ram_we, ram_oe, busy;
  logic [1:0]    ram_data_size;

  logic          if3_req, if3_done, if3_err;
  logic [AW-1:0] if3_addr;
  logic [31:0]   if3_rdata;
  logic          d3_req, d3_we, d3_done, d3_err;
  logic [1:0]    d3_size;
  logic [AW-1:0] d3_addr;
  logic [31:0]   d3_wdata, d3_rdata;
  logic [AW-1:0] ram3_address;
  logic [31:0]   ram3_data_input, ram3_data_output;
  logic          ram3_cs, ram3_we, ram3_oe, busy3;
  logic [1:0]    ram3_data_size;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .ram_address(ram_address), .ram_data_input(ram_data_input),
    .ram_data_output(ram_data_output), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_data_size(ram_data_size), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if3_req), .if_addr(if3_addr), .if_done(if3_done), .if_err(if3_err),
    .if_rdata(if3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_size(d3_size), .d_addr(d3_addr), .d_wdata(d3_wdata),
    .d_done(d3_done), .d_err(d3_err), .d_rdata(d3_rdata),
    .ram_address(ram3_address), .ram_data_input(ram3_data_input),
    .ram_data_output(ram3_data_output), .ram_cs(ram3_cs), .ram_we(ram3_we), .ram_oe(ram3_oe),
    .ram_data_size(ram3_data_size), .busy(busy3)
  );

  // Main RAM: combinational read while selected, byte-lane writes on the clock edge.
  logic [7:0]    mem     [0:16383];
  logic [7:0]    ref_mem [0:16383];
  logic          mem_clr, pk_en;
  logic [AW-1:0] pk_addr;
  logic [7:0]    pk_data;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
    end else if (pk_en) begin
      mem[pk_addr] <= pk_data;
    end else if (ram_cs && ram_we) begin
      mem[ram_address] <= ram_data_input[7:0];
      if (ram_data_size != 2'b00) mem[ram_address + AW'(1)] <= ram_data_input[15:8];
      if (ram_data_size == 2'b11) begin
        mem[ram_address + AW'(2)] <= ram_data_input[23:16];
        mem[ram_address + AW'(3)] <= ram_data_input[31:24];
      end
    end
  end

  always_comb begin
    ram_data_output = 'z;
    if (ram_cs && ram_oe)
      ram_data_output = {mem[ram_address + AW'(3)], mem[ram_address + AW'(2)],
                         mem[ram_address + AW'(1)], mem[ram_address]};
  end

  // Second RAM returns an address-derived pattern.
  always_comb begin
    ram3_data_output = 'z;
    if (ram3_cs && ram3_oe) ram3_data_output = {2'b00, ram3_address, 16'hA5C3};
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b10) ? 2 : 4;
  endfunction

  function automatic logic model_bad(input logic [AW-1:0] a, input logic [1:0] sz);
    return (sz == 2'b01) || ((int'(a) % size_bytes(sz)) != 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a, input logic [1:0] sz);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < size_bytes(sz); k++)
      v = v | (32'(ref_mem[a + AW'(k)]) << (8 * k));
    return v;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [1:0] sz,
                             input logic [31:0] wd);
    for (int k = 0; k < size_bytes(sz); k++) ref_mem[a + AW'(k)] = 8'(wd >> (8 * k));
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    pk_en = 1'b1; pk_addr = a; pk_data = b;
    @(posedge clk); #1;
    pk_en = 1'b0;
    ref_mem[a] = b;
  endtask

  task automatic do_data(input logic we, input logic [1:0] sz, input logic [AW-1:0] a,
                         input logic [31:0] wd, output logic [31:0] got);
    logic        bad;
    logic [31:0] exp_rd;
    int          seen, cs_cnt;
    bad    = model_bad(a, sz);
    exp_rd = (bad || we) ? 32'h0 : model_read(a, sz);
    got    = 32'h0;
    @(posedge clk); #1;
    d_we = we; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
    @(posedge clk);
    seen = 0; cs_cnt = 0;
    for (int j = 1; j <= 12 && seen == 0; j++) begin
      @(negedge clk);
      if (ram_cs) cs_cnt++;
      if (d_done) begin
        seen = j;
        got  = d_rdata;
        check("d_err", 32'(d_err), 32'(bad));
        check("d_rdata", d_rdata, exp_rd);
      end
    end
    d_req = 1'b0;
    check("d_latency", 32'(seen), bad ? 32'd1 : 32'(LAT + 1));
    check("d_cs_cycles", 32'(cs_cnt), bad ? 32'd0 : 32'(LAT));
    if (!bad && we) model_write(a, sz, wd);
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, output logic [31:0] got);
    logic bad;
    int   seen;
    bad = model_bad(a, 2'b11);
    got = 32'h0;
    @(posedge clk); #1;
    if_addr = a; if_req = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int j = 1; j <= 12 && seen == 0; j++) begin
      @(negedge clk);
      if (if_done) begin
        seen = j;
        got  = if_rdata;
        check("if_err", 32'(if_err), 32'(bad));
        check("if_rdata", if_rdata, bad ? 32'h0 : model_read(a, 2'b11));
      end
    end
    if_req = 1'b0;
    check("if_latency", 32'(seen), bad ? 32'd1 : 32'(LAT + 1));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    int          ev, seen, cs_cnt, busy_cnt, bad_bytes;

    rst = 1'b1; mem_clr = 1'b0; pk_en = 1'b0; pk_addr = '0; pk_data = 8'h00;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = 32'h0;
    if3_req = 1'b0; if3_addr = '0;
    d3_req = 1'b0; d3_we = 1'b0; d3_size = 2'b00; d3_addr = '0; d3_wdata = 32'h0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    check("rst_done_err", {28'd0, if_done, if_err, d_done, d_err}, 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'h0);

    @(posedge clk); #1;
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    rst = 1'b0;

    // Fetch of a preloaded little-endian word.
    poke(14'h010, 8'hEF); poke(14'h011, 8'hBE); poke(14'h012, 8'hAD); poke(14'h013, 8'hDE);
    do_fetch(14'h010, got);
    check("fetch_word", got, 32'hDEADBEEF);

    do_data(1'b1, 2'b11, 14'h020, 32'h13579BDF, got);
    check("write_rdata_zero", got, 32'h0);

    // Both ports held: fetch wins the first tie after reset, then strict alternation.
    pulse_reset();
    @(posedge clk); #1;
    if_addr = 14'h010; if_req = 1'b1;
    d_we = 1'b0; d_size = 2'b11; d_addr = 14'h020; d_req = 1'b1;
    @(posedge clk);
    ev = 0;
    for (int j = 1; j <= 40 && ev < 4; j++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        check("tie_not_both", 32'(if_done & d_done), 32'd0);
        check("tie_order", 32'(if_done), 32'((ev % 2) == 0));
        check("tie_spacing", 32'(j), 32'(2 + (LAT + 2) * ev));
        if (if_done) check("tie_if_rdata", if_rdata, model_read(14'h010, 2'b11));
        else check("tie_d_rdata", d_rdata, model_read(14'h020, 2'b11));
        ev++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("tie_events", 32'(ev), 32'd4);
    for (int j = 0; j < 10 && busy; j++) @(negedge clk);
    check("tie_idle", 32'(busy), 32'd0);

    // Byte lane placement and zero extension.
    do_data(1'b1, 2'b00, 14'h041, 32'hAABBCC5A, got);
    do_data(1'b0, 2'b11, 14'h040, 32'h0, got);
    check("byte_in_word", got, 32'h00005A00);
    do_data(1'b0, 2'b00, 14'h041, 32'h0, got);
    check("byte_read", got, 32'h0000005A);
    do_data(1'b0, 2'b10, 14'h020, 32'h0, got);
    check("half_read", got, 32'h00009BDF);

    // Rejected accesses: must not touch RAM.
    do_data(1'b0, 2'b10, 14'h003, 32'h0, got);
    do_data(1'b1, 2'b11, 14'h022, 32'hFFFFFFFF, got);
    do_data(1'b1, 2'b01, 14'h030, 32'hFFFFFFFF, got);
    do_fetch(14'h012, got);

    // Highest aligned word.
    do_data(1'b1, 2'b11, 14'h3FFC, 32'hCAFEF00D, got);
    do_data(1'b0, 2'b11, 14'h3FFC, 32'h0, got);
    check("top_word", got, 32'hCAFEF00D);

    // Three-cycle access build.
    @(posedge clk); #1;
    d3_we = 1'b0; d3_size = 2'b11; d3_addr = 14'h008; d3_req = 1'b1;
    @(posedge clk);
    seen = 0; cs_cnt = 0; busy_cnt = 0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (ram3_cs) cs_cnt++;
      if (busy3) busy_cnt++;
      if (d3_done && seen == 0) begin
        seen = j;
        check("lat3_rdata", d3_rdata, {2'b00, 14'h008, 16'hA5C3});
        d3_req = 1'b0;
      end
    end
    check("lat3_done_cycle", 32'(seen), 32'd4);
    check("lat3_cs_cycles", 32'(cs_cnt), 32'd3);
    check("lat3_busy_cycles", 32'(busy_cnt), 32'd4);

    // Reset during the first access cycle of a read; fetch queued behind it.
    @(posedge clk); #1;
    d_we = 1'b0; d_size = 2'b11; d_addr = 14'h020; d_req = 1'b1;
    @(posedge clk);
    #2;
    check("mid_pre_cs", 32'(ram_cs), 32'd1);
    if_addr = 14'h010; if_req = 1'b1; rst = 1'b1;
    #1;
    check("mid_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rdata", if_rdata | d_rdata, 32'h0);
    ev = 0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      if (if_done || d_done) ev++;
    end
    check("mid_no_done", 32'(ev), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    seen = 0;
    for (int j = 1; j <= 12 && seen == 0; j++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        seen = j;
        check("post_rst_fetch_first", {30'd0, if_done, d_done}, 32'd2);
        check("post_rst_if_rdata", if_rdata, 32'hDEADBEEF);
      end
    end
    if_req = 1'b0;
    check("post_rst_latency", 32'(seen), 32'(LAT + 1));
    seen = 0;
    for (int j = 1; j <= 12 && seen == 0; j++) begin
      @(negedge clk);
      if (d_done) begin
        seen = j;
        check("post_rst_d_rdata", d_rdata, model_read(14'h020, 2'b11));
      end
    end
    d_req = 1'b0;
    check("post_rst_d_seen", 32'(seen != 0), 32'd1);

    // Randomized mix over a small window so reads meet earlier writes.
    for (int n = 0; n < 80; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~AW'(3);
      if ($urandom_range(0, 4) == 0) do_fetch(a, got);
      else do_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, got);
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    bad_bytes = 0;
    for (int i = 0; i < 16384; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
    check("ram_image", 32'(bad_bytes), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
